// File: rtl/bank_sched_pkg.sv
// Shared types for the two-bank DP/traceback scheduler: bank and FSM state
// encodings plus the default coordinate width.
package bank_sched_pkg;

    localparam int ADDR_W_DEF = 10;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        FILLED  = 2'd1,
        TRACING = 2'd2
    } bank_state_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LAUNCH  = 2'd1,
        RUN     = 2'd2,
        RELEASE = 2'd3
    } sched_state_t;

endpackage

// File: rtl/bank_sched_if.sv
// DP-side and traceback-side handshake bundle of bank_sched.
// master = scheduler, slave = the DP / traceback engines around it.
interface bank_sched_if #(
    parameter int ADDR_W = bank_sched_pkg::ADDR_W_DEF
);
    logic              dp_done_i;
    logic [ADDR_W-1:0] dp_max_x_i;
    logic [ADDR_W-1:0] dp_max_y_i;
    logic              dp_wr_bank_o;
    logic              dp_stall_o;
    logic              tb_valid_o;
    logic              tb_bank_o;
    logic [ADDR_W-1:0] tb_x_o;
    logic [ADDR_W-1:0] tb_y_o;
    logic              tb_busy_i;
    logic              tb_done_i;

    modport master (
        input  dp_done_i, dp_max_x_i, dp_max_y_i, tb_busy_i, tb_done_i,
        output dp_wr_bank_o, dp_stall_o, tb_valid_o, tb_bank_o, tb_x_o, tb_y_o
    );

    modport slave (
        output dp_done_i, dp_max_x_i, dp_max_y_i, tb_busy_i, tb_done_i,
        input  dp_wr_bank_o, dp_stall_o, tb_valid_o, tb_bank_o, tb_x_o, tb_y_o
    );
endinterface

// File: rtl/bank_slot.sv
// One score-matrix bank: occupancy state, latched max-score point and the
// fill-order tag used to pick the older bank when both are waiting.
module bank_slot
    import bank_sched_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              fill,
    input  logic              start,
    input  logic              free_req,
    input  logic [ADDR_W-1:0] fill_x,
    input  logic [ADDR_W-1:0] fill_y,
    input  logic              fill_tag,
    output bank_state_t       state,
    output logic [ADDR_W-1:0] x,
    output logic [ADDR_W-1:0] y,
    output logic              tag
);
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state <= FREE;
            x     <= '0;
            y     <= '0;
            tag   <= 1'b0;
        end else if (fill) begin
            state <= FILLED;
            x     <= fill_x;
            y     <= fill_y;
            tag   <= fill_tag;
        end else if (start) begin
            state <= TRACING;
        end else if (free_req) begin
            state <= FREE;
        end
    end
endmodule

// File: rtl/bank_sched.sv
// Ping-pong bank scheduler between the DP fill engine and the traceback engine.
// Optional traceback watchdog: define SCHED_TIMEOUT_EN (adds the tmo_o port).
module bank_sched
    import bank_sched_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic         clk,
    input  logic         reset_i,
    bank_sched_if.master bus,
    output logic         ovf_o,
    output logic [15:0]  job_cnt_o
`ifdef SCHED_TIMEOUT_EN
    ,
    output logic         tmo_o
`endif
);
    bank_state_t       st   [2];
    logic [ADDR_W-1:0] sx   [2];
    logic [ADDR_W-1:0] sy   [2];
    logic              stag [2];

    sched_state_t state, state_nx;
    logic wr_bank, fill_ctr, fill_seen, stall, accept;
    logic filled0, filled1, pick, launch_go, tmo_fire, tmo_job;
    logic unused_ok;

    // tb_busy_i is informational only; completion is signalled by tb_done_i.
    assign unused_ok = bus.tb_busy_i ^ (TIMEOUT_CYC > 0);

    assign stall            = (st[wr_bank] != FREE);
    assign accept           = bus.dp_done_i && !stall;
    assign bus.dp_stall_o   = stall;
    assign bus.dp_wr_bank_o = wr_bank;
    assign filled0          = (st[0] == FILLED);
    assign filled1          = (st[1] == FILLED);
    // fill_seen delays launch by one cycle after the first fill, giving the
    // three-cycle dp_done -> tb_valid latency.
    assign launch_go        = (state == IDLE) && fill_seen && (filled0 || filled1);

    for (genvar b = 0; b < 2; b++) begin : g_slot
        bank_slot #(.ADDR_W(ADDR_W)) u_slot (
            .clk      (clk),
            .reset_i  (reset_i),
            .fill     (accept && (wr_bank == 1'(b))),
            .start    ((state == LAUNCH) && (bus.tb_bank_o == 1'(b))),
            .free_req ((state == RELEASE) && (bus.tb_bank_o == 1'(b))),
            .fill_x   (bus.dp_max_x_i),
            .fill_y   (bus.dp_max_y_i),
            .fill_tag (fill_ctr),
            .state    (st[b]),
            .x        (sx[b]),
            .y        (sy[b]),
            .tag      (stag[b])
        );
    end

    // With both banks waiting, the older one carries the tag equal to the
    // current fill counter (the counter has flipped twice since it was filled).
    always_comb begin
        pick = filled1;
        if (filled0 && filled1)
            pick = (stag[0] != fill_ctr) && (stag[1] == fill_ctr);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (launch_go) state_nx = LAUNCH;
            LAUNCH:  state_nx = RUN;
            RUN:     if (bus.tb_done_i || tmo_fire) state_nx = RELEASE;
            RELEASE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state          <= IDLE;
            wr_bank        <= 1'b0;
            fill_ctr       <= 1'b0;
            fill_seen      <= 1'b0;
            ovf_o          <= 1'b0;
            job_cnt_o      <= '0;
            bus.tb_valid_o <= 1'b0;
            bus.tb_bank_o  <= 1'b0;
            bus.tb_x_o     <= '0;
            bus.tb_y_o     <= '0;
        end else begin
            state          <= state_nx;
            fill_seen      <= filled0 || filled1;
            bus.tb_valid_o <= (state_nx == LAUNCH) || (state_nx == RUN);
            if (accept) begin
                wr_bank  <= ~wr_bank;
                fill_ctr <= ~fill_ctr;
            end
            if (bus.dp_done_i && stall)
                ovf_o <= 1'b1;
            if (launch_go) begin
                bus.tb_bank_o <= pick;
                bus.tb_x_o    <= sx[pick];
                bus.tb_y_o    <= sy[pick];
            end
            if ((state == RELEASE) && !tmo_job)
                job_cnt_o <= job_cnt_o + 16'd1;
        end
    end

`ifdef SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
    logic [TMO_W-1:0] tmo_cnt;

    assign tmo_fire = (state == RUN) && !bus.tb_done_i &&
                      (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            tmo_cnt <= '0;
            tmo_job <= 1'b0;
            tmo_o   <= 1'b0;
        end else begin
            tmo_cnt <= (state == RUN) ? tmo_cnt + 1'b1 : '0;
            if (tmo_fire) begin
                tmo_job <= 1'b1;
                tmo_o   <= 1'b1;
            end else if (state == RELEASE) begin
                tmo_job <= 1'b0;
            end
        end
    end
`else
    assign tmo_fire = 1'b0;
    assign tmo_job  = 1'b0;
`endif

endmodule

// File: tb/tb_bank_sched.sv
// Directed bench for bank_sched with a launch scoreboard: each accepted fill
// pushes the expected (bank,x,y), each tb_valid rise pops and compares it.
module tb_bank_sched;
    localparam int AW = 10;

    typedef struct packed {
        logic          bank;
        logic [AW-1:0] x;
        logic [AW-1:0] y;
    } launch_t;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        ovf;
    logic [15:0] job_cnt;
`ifdef SCHED_TIMEOUT_EN
    logic        tmo;
`endif

    int vectors     = 0;
    int miscompares = 0;
    launch_t sb[$];

    bank_sched_if #(.ADDR_W(AW)) bus ();

    bank_sched #(.ADDR_W(AW), .TIMEOUT_CYC(16)) dut (
        .clk       (clk),
        .reset_i   (reset_i),
        .bus       (bus),
        .ovf_o     (ovf),
        .job_cnt_o (job_cnt)
`ifdef SCHED_TIMEOUT_EN
        ,
        .tmo_o     (tmo)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_done(input logic [AW-1:0] x, input logic [AW-1:0] y);
        bus.dp_done_i  = 1'b1;
        bus.dp_max_x_i = x;
        bus.dp_max_y_i = y;
        tick();
        bus.dp_done_i  = 1'b0;
    endtask

    task automatic expect_launch(input logic b, input logic [AW-1:0] x, input logic [AW-1:0] y);
        launch_t e;
        e.bank = b;
        e.x    = x;
        e.y    = y;
        sb.push_back(e);
    endtask

    task automatic wait_launch(input int bound);
        int n = 0;
        launch_t e;
        while (bus.tb_valid_o !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check("launch_seen", 32'(bus.tb_valid_o), 32'd1);
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check("launch_bank", 32'(bus.tb_bank_o), 32'(e.bank));
            check("launch_x", 32'(bus.tb_x_o), 32'(e.x));
            check("launch_y", 32'(bus.tb_y_o), 32'(e.y));
        end
    endtask

    task automatic pulse_tb_done();
        bus.tb_done_i = 1'b1;
        tick();
        bus.tb_done_i = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"}, 32'(bus.tb_valid_o), 32'd0);
        check({tag, "_bank"},  32'(bus.tb_bank_o), 32'd0);
        check({tag, "_x"},     32'(bus.tb_x_o), 32'd0);
        check({tag, "_y"},     32'(bus.tb_y_o), 32'd0);
        check({tag, "_wr"},    32'(bus.dp_wr_bank_o), 32'd0);
        check({tag, "_stall"}, 32'(bus.dp_stall_o), 32'd0);
        check({tag, "_ovf"},   32'(ovf), 32'd0);
        check({tag, "_jobs"},  32'(job_cnt), 32'd0);
    endtask

    initial begin
        reset_i        = 1'b0;
        bus.dp_done_i  = 1'b0;
        bus.dp_max_x_i = '0;
        bus.dp_max_y_i = '0;
        bus.tb_busy_i  = 1'b0;
        bus.tb_done_i  = 1'b0;
        #2;
        check_reset("por");
        tick();
        tick();
        reset_i = 1'b1;
        tick();

        // Single job from idle: 3-cycle launch latency.
        expect_launch(1'b0, 10'd5, 10'd7);
        pulse_done(10'd5, 10'd7);
        check("wr_after_fill", 32'(bus.dp_wr_bank_o), 32'd1);
        check("stall_after_fill", 32'(bus.dp_stall_o), 32'd0);
        check("valid_lat1", 32'(bus.tb_valid_o), 32'd0);
        tick();
        check("valid_lat2", 32'(bus.tb_valid_o), 32'd0);
        tick();
        wait_launch(0);
        tick();
        check("valid_run", 32'(bus.tb_valid_o), 32'd1);
        pulse_tb_done();
        check("valid_release", 32'(bus.tb_valid_o), 32'd0);
        check("jobs_in_release", 32'(job_cnt), 32'd0);
        tick();
        check("jobs_after_1", 32'(job_cnt), 32'd1);

        // tb_done outside RUN is ignored.
        pulse_tb_done();
        tick();
        tick();
        check("jobs_done_idle", 32'(job_cnt), 32'd1);
        check("valid_done_idle", 32'(bus.tb_valid_o), 32'd0);

        reset_i = 1'b0;
        #1;
        check_reset("rst_idle");
        tick();
        reset_i = 1'b1;
        tick();

        // Both banks filled while traceback busy; older bank 0 goes first.
        bus.tb_busy_i = 1'b1;
        expect_launch(1'b0, 10'd1, 10'd1);
        pulse_done(10'd1, 10'd1);
        expect_launch(1'b1, 10'd2, 10'd2);
        pulse_done(10'd2, 10'd2);
        check("stall_both", 32'(bus.dp_stall_o), 32'd1);
        check("wr_both", 32'(bus.dp_wr_bank_o), 32'd0);
        check("ovf_before", 32'(ovf), 32'd0);
        tick();
        wait_launch(0);

        // Fill while stalled: dropped, flagged.
        pulse_done(10'd9, 10'd9);
        check("ovf_set", 32'(ovf), 32'd1);
        check("stall_kept", 32'(bus.dp_stall_o), 32'd1);
        check("wr_kept", 32'(bus.dp_wr_bank_o), 32'd0);
        tick();
        check("valid_busy", 32'(bus.tb_valid_o), 32'd1);
        pulse_tb_done();
        check("gap1_valid", 32'(bus.tb_valid_o), 32'd0);
        check("gap1_stall", 32'(bus.dp_stall_o), 32'd1);
        tick();
        check("gap2_valid", 32'(bus.tb_valid_o), 32'd0);
        check("stall_cleared", 32'(bus.dp_stall_o), 32'd0);
        check("jobs_after_2", 32'(job_cnt), 32'd1);
        tick();
        wait_launch(0);

        // Fill in the same cycle as RELEASE, then reuse the freed bank.
        tick();
        pulse_tb_done();
        expect_launch(1'b0, 10'd3, 10'd4);
        pulse_done(10'd3, 10'd4);
        check("jobs_same_cycle", 32'(job_cnt), 32'd2);
        check("wr_same_cycle", 32'(bus.dp_wr_bank_o), 32'd1);
        check("stall_same_cycle", 32'(bus.dp_stall_o), 32'd0);
        expect_launch(1'b1, 10'd6, 10'd8);
        pulse_done(10'd6, 10'd8);
        check("stall_reuse", 32'(bus.dp_stall_o), 32'd1);
        wait_launch(4);
        tick();
        pulse_tb_done();
        tick();
        check("jobs_after_3", 32'(job_cnt), 32'd3);
        wait_launch(4);
        tick();
        check("valid_last_run", 32'(bus.tb_valid_o), 32'd1);
        check("ovf_sticky", 32'(ovf), 32'd1);

        // Reset mid-RUN abandons the job.
        reset_i = 1'b0;
        #1;
        check_reset("rst_run");
        tick();
        reset_i = 1'b1;
        tick();
        tick();
        tick();
        check("valid_after_rst", 32'(bus.tb_valid_o), 32'd0);
        check("jobs_after_rst", 32'(job_cnt), 32'd0);

`ifdef SCHED_TIMEOUT_EN
        expect_launch(1'b0, 10'd11, 10'd12);
        pulse_done(10'd11, 10'd12);
        wait_launch(4);
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("tmo_still_run", 32'(bus.tb_valid_o), 32'd1);
        check("tmo_not_yet", 32'(tmo), 32'd0);
        tick();
        check("tmo_release", 32'(bus.tb_valid_o), 32'd0);
        check("tmo_flag", 32'(tmo), 32'd1);
        tick();
        check("tmo_jobs", 32'(job_cnt), 32'd0);
        check("tmo_stall", 32'(bus.dp_stall_o), 32'd0);
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
